// File: rtl/axi_id_remap_compact_pkg.sv
// axi_id_remap_pkg: shared sizing helpers and the table entry layout for the
// AXI ID remapper.
// Contents:
//   num_slots() - number of table slots for a given outgoing ID width
//   cnt_width() - width of an outstanding-transaction counter
//   DEF_*       - default configuration (12-bit wide IDs, 2-bit narrow IDs, 4 txns/slot)
//   entry_t     - {valid, wide id, cnt} entry for the default configuration
package axi_id_remap_pkg;

  function automatic int num_slots(input int out_id_width);
    return 1 << out_id_width;
  endfunction

  // The counter must be able to hold MAX_TXNS itself, hence the +1.
  function automatic int cnt_width(input int max_txns);
    return $clog2(max_txns + 1);
  endfunction

  localparam int DEF_IN_ID_WIDTH  = 12;
  localparam int DEF_OUT_ID_WIDTH = 2;
  localparam int DEF_MAX_TXNS     = 4;
  localparam int DEF_NUM_SLOTS    = num_slots(DEF_OUT_ID_WIDTH);
  localparam int DEF_CNT_WIDTH    = cnt_width(DEF_MAX_TXNS);

  typedef struct packed {
    logic                       valid;
    logic [DEF_IN_ID_WIDTH-1:0] id;
    logic [DEF_CNT_WIDTH-1:0]   cnt;
  } entry_t;

endpackage

// File: rtl/axi_id_remap_compact_if.sv
// AXI_BUS: AXI4 bus bundle (AW, W, B, AR, R) with Master and Slave modports.
// Parameters set address/data/ID/user widths; a user width of 0 is carried as
// a single unused bit so the bundle stays legal.
interface AXI_BUS #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ID_WIDTH   = 12,
  parameter int AXI_USER_WIDTH = 0
);
  localparam int UW = (AXI_USER_WIDTH > 0) ? AXI_USER_WIDTH : 1;

  logic [AXI_ID_WIDTH-1:0]     aw_id;
  logic [AXI_ADDR_WIDTH-1:0]   aw_addr;
  logic [7:0]                  aw_len;
  logic [2:0]                  aw_size;
  logic [1:0]                  aw_burst;
  logic                        aw_lock;
  logic [3:0]                  aw_cache;
  logic [2:0]                  aw_prot;
  logic [3:0]                  aw_qos;
  logic [3:0]                  aw_region;
  logic [UW-1:0]               aw_user;
  logic                        aw_valid;
  logic                        aw_ready;

  logic [AXI_DATA_WIDTH-1:0]   w_data;
  logic [AXI_DATA_WIDTH/8-1:0] w_strb;
  logic                        w_last;
  logic [UW-1:0]               w_user;
  logic                        w_valid;
  logic                        w_ready;

  logic [AXI_ID_WIDTH-1:0]     b_id;
  logic [1:0]                  b_resp;
  logic [UW-1:0]               b_user;
  logic                        b_valid;
  logic                        b_ready;

  logic [AXI_ID_WIDTH-1:0]     ar_id;
  logic [AXI_ADDR_WIDTH-1:0]   ar_addr;
  logic [7:0]                  ar_len;
  logic [2:0]                  ar_size;
  logic [1:0]                  ar_burst;
  logic                        ar_lock;
  logic [3:0]                  ar_cache;
  logic [2:0]                  ar_prot;
  logic [3:0]                  ar_qos;
  logic [3:0]                  ar_region;
  logic [UW-1:0]               ar_user;
  logic                        ar_valid;
  logic                        ar_ready;

  logic [AXI_ID_WIDTH-1:0]     r_id;
  logic [AXI_DATA_WIDTH-1:0]   r_data;
  logic [1:0]                  r_resp;
  logic                        r_last;
  logic [UW-1:0]               r_user;
  logic                        r_valid;
  logic                        r_ready;

  modport Master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache,
           aw_prot, aw_qos, aw_region, aw_user, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_user, w_valid,
    input  w_ready,
    input  b_id, b_resp, b_user, b_valid,
    output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache,
           ar_prot, ar_qos, ar_region, ar_user, ar_valid,
    input  ar_ready,
    input  r_id, r_data, r_resp, r_last, r_user, r_valid,
    output r_ready
  );

  modport Slave (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache,
           aw_prot, aw_qos, aw_region, aw_user, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_last, w_user, w_valid,
    output w_ready,
    output b_id, b_resp, b_user, b_valid,
    input  b_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache,
           ar_prot, ar_qos, ar_region, ar_user, ar_valid,
    output ar_ready,
    output r_id, r_data, r_resp, r_last, r_user, r_valid,
    input  r_ready
  );
endinterface

// File: rtl/axi_id_remap_compact_table.sv
// axi_id_remap_table: one direction's ID table (write or read).
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   i_req_id        - wide ID of the pending request
//   i_req_hs        - request handshake on the narrow side (commit to o_slot)
//   i_rsp_slot      - narrow ID of the response
//   i_rsp_pop       - response retires one transaction of i_rsp_slot
//   o_avail         - a slot can take the pending request
//   o_slot          - slot chosen for the pending request (the narrow ID)
//   o_rsp_wide_id   - wide ID stored in i_rsp_slot
module axi_id_remap_table
  import axi_id_remap_pkg::*;
#(
  parameter int ID_WIDTH   = 12,
  parameter int SLOT_WIDTH = 2,
  parameter int MAX_TXNS   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ID_WIDTH-1:0]   i_req_id,
  input  logic                  i_req_hs,
  input  logic [SLOT_WIDTH-1:0] i_rsp_slot,
  input  logic                  i_rsp_pop,
  output logic                  o_avail,
  output logic [SLOT_WIDTH-1:0] o_slot,
  output logic [ID_WIDTH-1:0]   o_rsp_wide_id
);
  localparam int NS = num_slots(SLOT_WIDTH);
  localparam int CW = cnt_width(MAX_TXNS);

  logic [NS-1:0]       r_valid;
  logic [ID_WIDTH-1:0] r_id  [NS];
  logic [CW-1:0]       r_cnt [NS];

  logic [NS-1:0]         w_hit;
  logic [NS-1:0]         w_push;
  logic [NS-1:0]         w_pop;
  logic                  w_hit_any;
  logic                  w_free_any;
  logic [SLOT_WIDTH-1:0] w_hit_idx;
  logic [SLOT_WIDTH-1:0] w_free_idx;
  logic [SLOT_WIDTH-1:0] w_slot;
  logic                  w_hit_full;

  genvar gi;
  generate
    for (gi = 0; gi < NS; gi++) begin : g_slot
      assign w_hit[gi]  = r_valid[gi] && (r_id[gi] == i_req_id);
      assign w_push[gi] = i_req_hs && (w_slot == SLOT_WIDTH'(gi));
      // An empty counter is never decremented, even on a bogus response.
      assign w_pop[gi]  = i_rsp_pop && (i_rsp_slot == SLOT_WIDTH'(gi)) &&
                          (r_cnt[gi] != '0);
    end
  endgenerate

  // Lookup works on registered state only. The descending scan leaves the
  // lowest-index free slot selected; at most one entry can hit.
  always_comb begin
    w_hit_any  = 1'b0;
    w_free_any = 1'b0;
    w_hit_idx  = '0;
    w_free_idx = '0;
    for (int i = NS - 1; i >= 0; i--) begin
      if (!r_valid[i]) begin
        w_free_any = 1'b1;
        w_free_idx = SLOT_WIDTH'(i);
      end
      if (w_hit[i]) begin
        w_hit_any = 1'b1;
        w_hit_idx = SLOT_WIDTH'(i);
      end
    end
    w_hit_full = (r_cnt[w_hit_idx] == CW'(MAX_TXNS));
    w_slot     = w_hit_any ? w_hit_idx : w_free_idx;
    o_avail    = w_hit_any ? !w_hit_full : w_free_any;
  end

  assign o_slot        = w_slot;
  assign o_rsp_wide_id = r_id[i_rsp_slot];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
      for (int i = 0; i < NS; i++) begin
        r_id[i]  <= '0;
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NS; i++) begin
        if (w_push[i]) begin
          r_valid[i] <= 1'b1;
          r_id[i]    <= i_req_id;
        end
        // Push and pop on the same slot cancel; the slot stays allocated.
        if (w_push[i] && !w_pop[i]) begin
          r_cnt[i] <= r_cnt[i] + CW'(1);
        end else if (w_pop[i] && !w_push[i]) begin
          r_cnt[i] <= r_cnt[i] - CW'(1);
          if (r_cnt[i] == CW'(1)) begin
            r_valid[i] <= 1'b0;
          end
        end
      end
    end
  end

  // A response for a slot with nothing outstanding is a protocol error.
  always @(posedge clk) begin
    if (!rst && i_rsp_pop) begin
      assert (r_cnt[i_rsp_slot] != '0);
    end
  end

endmodule

// File: rtl/axi_id_remap_compact.sv
// axi_id_remap_compact: compresses wide node-side AXI IDs to narrow IO-side
// IDs by allocating a table slot per in-flight wide ID, and restores the
// wide ID on B/R responses. Everything except the IDs and the request
// valid/ready gating passes through combinationally.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset; forces mst valids / slv readies low
//   slv  - AXI_BUS.Slave from the node master port, IN_ID_WIDTH IDs
//   mst  - AXI_BUS.Master to the IO port, OUT_ID_WIDTH IDs
module axi_id_remap_compact
  import axi_id_remap_pkg::*;
#(
  parameter int IN_ID_WIDTH  = DEF_IN_ID_WIDTH,
  parameter int OUT_ID_WIDTH = DEF_OUT_ID_WIDTH,
  parameter int MAX_TXNS     = DEF_MAX_TXNS
) (
  input logic   clk,
  input logic   rst,
  AXI_BUS.Slave  slv,
  AXI_BUS.Master mst
);
  logic                    w_run;
  logic                    w_aw_avail;
  logic                    w_ar_avail;
  logic [OUT_ID_WIDTH-1:0] w_aw_slot;
  logic [OUT_ID_WIDTH-1:0] w_ar_slot;
  logic [IN_ID_WIDTH-1:0]  w_b_wide_id;
  logic [IN_ID_WIDTH-1:0]  w_r_wide_id;
  logic                    w_aw_hs;
  logic                    w_ar_hs;
  logic                    w_b_pop;
  logic                    w_r_pop;

  assign w_run = !rst;

  assign w_aw_hs = slv.aw_valid & mst.aw_ready & w_aw_avail & w_run;
  assign w_ar_hs = slv.ar_valid & mst.ar_ready & w_ar_avail & w_run;
  assign w_b_pop = mst.b_valid & slv.b_ready & w_run;
  // Read transactions retire only on the last beat of the burst.
  assign w_r_pop = mst.r_valid & slv.r_ready & mst.r_last & w_run;

  axi_id_remap_table #(
    .ID_WIDTH   (IN_ID_WIDTH),
    .SLOT_WIDTH (OUT_ID_WIDTH),
    .MAX_TXNS   (MAX_TXNS)
  ) u_wr_table (
    .clk           (clk),
    .rst           (rst),
    .i_req_id      (slv.aw_id),
    .i_req_hs      (w_aw_hs),
    .i_rsp_slot    (mst.b_id),
    .i_rsp_pop     (w_b_pop),
    .o_avail       (w_aw_avail),
    .o_slot        (w_aw_slot),
    .o_rsp_wide_id (w_b_wide_id)
  );

  axi_id_remap_table #(
    .ID_WIDTH   (IN_ID_WIDTH),
    .SLOT_WIDTH (OUT_ID_WIDTH),
    .MAX_TXNS   (MAX_TXNS)
  ) u_rd_table (
    .clk           (clk),
    .rst           (rst),
    .i_req_id      (slv.ar_id),
    .i_req_hs      (w_ar_hs),
    .i_rsp_slot    (mst.r_id),
    .i_rsp_pop     (w_r_pop),
    .o_avail       (w_ar_avail),
    .o_slot        (w_ar_slot),
    .o_rsp_wide_id (w_r_wide_id)
  );

  // AW
  assign mst.aw_id     = w_aw_slot;
  assign mst.aw_addr   = slv.aw_addr;
  assign mst.aw_len    = slv.aw_len;
  assign mst.aw_size   = slv.aw_size;
  assign mst.aw_burst  = slv.aw_burst;
  assign mst.aw_lock   = slv.aw_lock;
  assign mst.aw_cache  = slv.aw_cache;
  assign mst.aw_prot   = slv.aw_prot;
  assign mst.aw_qos    = slv.aw_qos;
  assign mst.aw_region = slv.aw_region;
  assign mst.aw_user   = slv.aw_user;
  assign mst.aw_valid  = slv.aw_valid & w_aw_avail & w_run;
  assign slv.aw_ready  = mst.aw_ready & w_aw_avail & w_run;

  // W
  assign mst.w_data  = slv.w_data;
  assign mst.w_strb  = slv.w_strb;
  assign mst.w_last  = slv.w_last;
  assign mst.w_user  = slv.w_user;
  assign mst.w_valid = slv.w_valid & w_run;
  assign slv.w_ready = mst.w_ready & w_run;

  // B
  assign slv.b_id    = w_b_wide_id;
  assign slv.b_resp  = mst.b_resp;
  assign slv.b_user  = mst.b_user;
  assign slv.b_valid = mst.b_valid & w_run;
  assign mst.b_ready = slv.b_ready & w_run;

  // AR
  assign mst.ar_id     = w_ar_slot;
  assign mst.ar_addr   = slv.ar_addr;
  assign mst.ar_len    = slv.ar_len;
  assign mst.ar_size   = slv.ar_size;
  assign mst.ar_burst  = slv.ar_burst;
  assign mst.ar_lock   = slv.ar_lock;
  assign mst.ar_cache  = slv.ar_cache;
  assign mst.ar_prot   = slv.ar_prot;
  assign mst.ar_qos    = slv.ar_qos;
  assign mst.ar_region = slv.ar_region;
  assign mst.ar_user   = slv.ar_user;
  assign mst.ar_valid  = slv.ar_valid & w_ar_avail & w_run;
  assign slv.ar_ready  = mst.ar_ready & w_ar_avail & w_run;

  // R
  assign slv.r_id    = w_r_wide_id;
  assign slv.r_data  = mst.r_data;
  assign slv.r_resp  = mst.r_resp;
  assign slv.r_last  = mst.r_last;
  assign slv.r_user  = mst.r_user;
  assign slv.r_valid = mst.r_valid & w_run;
  assign mst.r_ready = slv.r_ready & w_run;

endmodule

// File: tb/tb_axi_id_remap_compact.sv
// Directed bench for axi_id_remap_compact (IN_ID_WIDTH=12, OUT_ID_WIDTH=2,
// MAX_TXNS=4). Expected narrow IDs and restored wide IDs are queued when a
// request/response is driven and popped when the DUT presents it.
module tb_axi_id_remap_compact;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  AXI_BUS #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32), .AXI_ID_WIDTH(12), .AXI_USER_WIDTH(0)) slv_if ();
  AXI_BUS #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32), .AXI_ID_WIDTH(2),  .AXI_USER_WIDTH(0)) mst_if ();

  axi_id_remap_compact #(
    .IN_ID_WIDTH  (12),
    .OUT_ID_WIDTH (2),
    .MAX_TXNS     (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .slv (slv_if),
    .mst (mst_if)
  );

  int checks   = 0;
  int failures = 0;
  logic [31:0] aw_q[$];
  logic [31:0] ar_q[$];
  logic [31:0] b_q[$];
  logic [31:0] r_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
    $display("check %-16s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic do_aw(input logic [11:0] id, input logic [31:0] exp_slot);
    bit done = 0;
    logic [31:0] addr = $urandom;
    aw_q.push_back(exp_slot);
    slv_if.aw_valid = 1'b1; slv_if.aw_id = id; slv_if.aw_addr = addr; mst_if.aw_ready = 1'b1;
    for (int c = 0; c < 20 && !done; c++) begin
      #1;
      if (mst_if.aw_valid && slv_if.aw_ready) begin
        chk("aw_id", 32'(mst_if.aw_id), aw_q.pop_front());
        chk("aw_addr", mst_if.aw_addr, addr);
        done = 1;
      end
      @(posedge clk);
    end
    if (!done) begin
      chk("aw_timeout", 32'd0, 32'd1);
      void'(aw_q.pop_front());
    end
    #1 slv_if.aw_valid = 1'b0;
  endtask

  task automatic do_ar(input logic [11:0] id, input logic [7:0] len, input logic [31:0] exp_slot);
    bit done = 0;
    ar_q.push_back(exp_slot);
    slv_if.ar_valid = 1'b1; slv_if.ar_id = id; slv_if.ar_len = len; mst_if.ar_ready = 1'b1;
    for (int c = 0; c < 20 && !done; c++) begin
      #1;
      if (mst_if.ar_valid && slv_if.ar_ready) begin
        chk("ar_id", 32'(mst_if.ar_id), ar_q.pop_front());
        chk("ar_len", 32'(mst_if.ar_len), 32'(len));
        done = 1;
      end
      @(posedge clk);
    end
    if (!done) begin
      chk("ar_timeout", 32'd0, 32'd1);
      void'(ar_q.pop_front());
    end
    #1 slv_if.ar_valid = 1'b0;
  endtask

  task automatic do_b(input logic [1:0] slot, input logic [31:0] exp_wide);
    b_q.push_back(exp_wide);
    mst_if.b_valid = 1'b1; mst_if.b_id = slot; slv_if.b_ready = 1'b1;
    #1 chk("b_id", 32'(slv_if.b_id), b_q.pop_front());
    @(posedge clk);
    #1 mst_if.b_valid = 1'b0;
  endtask

  task automatic do_r(input logic [1:0] slot, input logic last, input logic [31:0] exp_wide);
    r_q.push_back(exp_wide);
    mst_if.r_valid = 1'b1; mst_if.r_id = slot; mst_if.r_last = last; slv_if.r_ready = 1'b1;
    #1 chk("r_id", 32'(slv_if.r_id), r_q.pop_front());
    @(posedge clk);
    #1 mst_if.r_valid = 1'b0;
  endtask

  initial begin
    slv_if.aw_valid = 0; slv_if.aw_id = '0; slv_if.aw_addr = '0; slv_if.aw_len = '0;
    slv_if.aw_size = '0; slv_if.aw_burst = '0; slv_if.aw_lock = 0; slv_if.aw_cache = '0;
    slv_if.aw_prot = '0; slv_if.aw_qos = '0; slv_if.aw_region = '0; slv_if.aw_user = '0;
    slv_if.w_valid = 0; slv_if.w_data = '0; slv_if.w_strb = '0; slv_if.w_last = 0; slv_if.w_user = '0;
    slv_if.b_ready = 0;
    slv_if.ar_valid = 0; slv_if.ar_id = '0; slv_if.ar_addr = '0; slv_if.ar_len = '0;
    slv_if.ar_size = '0; slv_if.ar_burst = '0; slv_if.ar_lock = 0; slv_if.ar_cache = '0;
    slv_if.ar_prot = '0; slv_if.ar_qos = '0; slv_if.ar_region = '0; slv_if.ar_user = '0;
    slv_if.r_ready = 0;
    mst_if.aw_ready = 0; mst_if.w_ready = 0; mst_if.ar_ready = 0;
    mst_if.b_valid = 0; mst_if.b_id = '0; mst_if.b_resp = '0; mst_if.b_user = '0;
    mst_if.r_valid = 0; mst_if.r_id = '0; mst_if.r_data = '0; mst_if.r_resp = '0;
    mst_if.r_last = 0; mst_if.r_user = '0;

    // Reset: requests offered on both sides must be blocked.
    slv_if.aw_valid = 1; mst_if.aw_ready = 1; slv_if.w_valid = 1; mst_if.w_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_aw_valid", 32'(mst_if.aw_valid), 0);
    chk("rst_aw_ready", 32'(slv_if.aw_ready), 0);
    chk("rst_w_valid", 32'(mst_if.w_valid), 0);
    chk("rst_wr_valid", 32'(dut.u_wr_table.r_valid), 0);
    slv_if.aw_valid = 0;
    rst = 0;
    @(posedge clk); #1;
    // W channel passes straight through once out of reset.
    slv_if.w_data = 32'hDEADBEEF;
    #1;
    chk("w_valid", 32'(mst_if.w_valid), 1);
    chk("w_data", mst_if.w_data, 32'hDEADBEEF);
    slv_if.w_valid = 0;
    @(posedge clk); #1;

    // 1. Single write
    do_aw(12'h2A5, 0);
    chk("t1_cnt0", 32'(dut.u_wr_table.r_cnt[0]), 1);
    do_b(2'd0, 32'h2A5);
    chk("t1_valid", 32'(dut.u_wr_table.r_valid), 0);

    // 2. Repeated ID shares one slot
    repeat (3) do_aw(12'h011, 0);
    chk("t2_cnt3", 32'(dut.u_wr_table.r_cnt[0]), 3);
    do_b(2'd0, 32'h011);
    chk("t2_cnt2", 32'(dut.u_wr_table.r_cnt[0]), 2);
    do_b(2'd0, 32'h011);
    chk("t2_cnt1", 32'(dut.u_wr_table.r_cnt[0]), 1);
    do_b(2'd0, 32'h011);
    chk("t2_cnt0", 32'(dut.u_wr_table.r_cnt[0]), 0);
    chk("t2_valid", 32'(dut.u_wr_table.r_valid), 0);

    // 3. Table full, then replacement one cycle after a slot drains
    do_aw(12'h100, 0);
    do_aw(12'h200, 1);
    do_aw(12'h300, 2);
    do_aw(12'h400, 3);
    slv_if.aw_valid = 1; slv_if.aw_id = 12'h500;
    #1;
    chk("t3_full_ready", 32'(slv_if.aw_ready), 0);
    chk("t3_full_valid", 32'(mst_if.aw_valid), 0);
    @(posedge clk); #1;
    aw_q.push_back(2);
    b_q.push_back(32'h300);
    mst_if.b_valid = 1; mst_if.b_id = 2'd2; slv_if.b_ready = 1;
    #1;
    chk("t3_b_id", 32'(slv_if.b_id), b_q.pop_front());
    chk("t3_same_cyc_rdy", 32'(slv_if.aw_ready), 0);
    @(posedge clk); #1;
    mst_if.b_valid = 0;
    #1;
    chk("t3_next_rdy", 32'(slv_if.aw_ready), 1);
    chk("t3_aw_id", 32'(mst_if.aw_id), aw_q.pop_front());
    @(posedge clk); #1;
    slv_if.aw_valid = 0;
    do_b(2'd0, 32'h100);
    do_b(2'd1, 32'h200);
    do_b(2'd2, 32'h500);
    do_b(2'd3, 32'h400);
    chk("t3_drained", 32'(dut.u_wr_table.r_valid), 0);

    // 4. Counter saturation on the read side
    repeat (4) do_ar(12'h007, 8'd0, 0);
    chk("t4_cnt4", 32'(dut.u_rd_table.r_cnt[0]), 4);
    slv_if.ar_valid = 1; slv_if.ar_id = 12'h007;
    #1;
    chk("t4_sat_ready", 32'(slv_if.ar_ready), 0);
    ar_q.push_back(0);
    r_q.push_back(32'h007);
    mst_if.r_valid = 1; mst_if.r_id = 2'd0; mst_if.r_last = 1; slv_if.r_ready = 1;
    #1;
    chk("t4_r_id", 32'(slv_if.r_id), r_q.pop_front());
    chk("t4_sat_ready2", 32'(slv_if.ar_ready), 0);
    @(posedge clk); #1;
    mst_if.r_valid = 0;
    #1;
    chk("t4_ready", 32'(slv_if.ar_ready), 1);
    chk("t4_ar_id", 32'(mst_if.ar_id), ar_q.pop_front());
    @(posedge clk); #1;
    slv_if.ar_valid = 0;
    chk("t4_cnt_back4", 32'(dut.u_rd_table.r_cnt[0]), 4);
    repeat (4) do_r(2'd0, 1'b1, 32'h007);
    chk("t4_drained", 32'(dut.u_rd_table.r_valid), 0);

    // 5. Read burst: only the last beat retires
    do_ar(12'h03C, 8'd3, 0);
    for (int b = 0; b < 3; b++) do_r(2'd0, 1'b0, 32'h03C);
    chk("t5_cnt1", 32'(dut.u_rd_table.r_cnt[0]), 1);
    do_r(2'd0, 1'b1, 32'h03C);
    chk("t5_freed", 32'(dut.u_rd_table.r_valid), 0);

    // 6a. Same-cycle push and pop on slot 1 with cnt=1
    do_aw(12'hAAA, 0);
    do_aw(12'h0BB, 1);
    aw_q.push_back(1);
    b_q.push_back(32'h0BB);
    slv_if.aw_valid = 1; slv_if.aw_id = 12'h0BB;
    mst_if.b_valid = 1; mst_if.b_id = 2'd1;
    #1;
    chk("t6_aw_ready", 32'(slv_if.aw_ready), 1);
    chk("t6_aw_id", 32'(mst_if.aw_id), aw_q.pop_front());
    chk("t6_b_id", 32'(slv_if.b_id), b_q.pop_front());
    @(posedge clk); #1;
    slv_if.aw_valid = 0; mst_if.b_valid = 0;
    chk("t6_valid1", 32'(dut.u_wr_table.r_valid[1]), 1);
    chk("t6_cnt1", 32'(dut.u_wr_table.r_cnt[1]), 1);

    // 6b. Reset in the middle of a read burst
    do_ar(12'h123, 8'd1, 0);
    do_r(2'd0, 1'b0, 32'h123);
    rst = 1;
    slv_if.ar_valid = 1; slv_if.ar_id = 12'h055; mst_if.ar_ready = 1;
    mst_if.r_valid = 1; mst_if.r_last = 1; slv_if.r_ready = 1;
    #1;
    chk("t6_rst_ar_valid", 32'(mst_if.ar_valid), 0);
    chk("t6_rst_r_ready", 32'(mst_if.r_ready), 0);
    chk("t6_rst_ar_ready", 32'(slv_if.ar_ready), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    slv_if.ar_valid = 0; mst_if.r_valid = 0;
    #1;
    chk("t6_wr_cleared", 32'(dut.u_wr_table.r_valid), 0);
    chk("t6_rd_cleared", 32'(dut.u_rd_table.r_valid), 0);
    chk("t6_rd_cnt0", 32'(dut.u_rd_table.r_cnt[0]), 0);
    @(posedge clk); #1;
    do_ar(12'h456, 8'd0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
